mc_alu_controller: RTL and testbench

//  Multi-cycle MIPS control FSM; the initiator side of the ALU interface. Decodes opcode/funct,

---
 rtl/mc_alu_controller_if.sv | 37 +++
 rtl/mc_alu_controller.sv | 174 +++++++++++++++++
 tb/tb_mc_alu_controller.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_alu_controller_if.sv
// Control/handshake bundle between the multi-cycle MIPS controller and its datapath.
// master: controller side (drives strobes, muxes, alu_op); slave: datapath/memory side.
interface mc_alu_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal, bus_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal, bus_err
    );
endinterface

// File: rtl/mc_alu_controller.sv
// Multi-cycle MIPS control FSM with memory-ready stall and timeout abort.
// Ports: clk, rst_n (async low), bus (mc_alu_controller_if.master). Macro MC_CTRL_BNE_EN adds BNE.
module mc_alu_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mc_alu_controller_if.master        bus
);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_SLTI_EX,
        S_IMM_WB, S_BEQ, S_BNE, S_JUMP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_st, timeout, funct_ok;

    always_comb begin
        mem_st  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                  (state_q == S_MEMWR);
        timeout = mem_st && !bus.mem_ready && (wait_cnt_q == CNT_LAST);
        funct_ok = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) ||
                   (bus.funct == 6'b101010);
    end

    // Next-state: timeout in any memory state aborts back to FETCH.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_START:    state_d = S_FETCH;
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    6'b000000: state_d = S_RTYPE_EX;
                    6'b100011,
                    6'b101011: state_d = S_MEMADR;
                    6'b000100: state_d = S_BEQ;
`ifdef MC_CTRL_BNE_EN
                    6'b000101: state_d = S_BNE;
`endif
                    6'b001000: state_d = S_ADDI_EX;
                    6'b001010: state_d = S_SLTI_EX;
                    6'b000010: state_d = S_JUMP;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready)  state_d = S_MEMWB;
                else if (timeout)   state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (bus.mem_ready || timeout) state_d = S_FETCH;
            end
            S_RTYPE_EX: state_d = funct_ok ? S_RTYPE_WB : S_FETCH;
            S_ADDI_EX,
            S_SLTI_EX:  state_d = S_IMM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Counter restarts on any state entry, including FETCH re-entry after timeout.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q || timeout)
            wait_cnt_d = '0;
        else if (mem_st && !bus.mem_ready)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_START;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Moore decode; only the handshake-qualified strobes look at inputs.
    always_comb begin
        bus.alu_op     = OP_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.pc_en      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.bus_err    = timeout;
        unique case (state_q)
            S_START:    bus.alu_op = 3'b000;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.illegal   = (state_d == S_FETCH);
            end
            S_MEMADR, S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_SLTI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = OP_SLT;
            end
            S_MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.iord       = 1'b1;
                bus.mem_write  = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_RTYPE_EX: begin
                bus.alu_src_a = 1'b1;
                bus.illegal   = !funct_ok;
                unique case (1'b1)
                    bus.funct == 6'b100010: bus.alu_op = OP_SUB;
                    bus.funct == 6'b101010: bus.alu_op = OP_SLT;
                    default:                bus.alu_op = OP_ADD;
                endcase
            end
            S_RTYPE_WB: begin
                bus.reg_dst    = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_IMM_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = OP_SUB;
                bus.pc_src     = 2'b01;
                bus.pc_en      = (state_q == S_BNE) ? !bus.zero : bus.zero;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src     = 2'b10;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_alu_controller.sv
// Randomized instruction-level bench for mc_alu_controller against a scripted model.
// Set MC_CTRL_BNE_EN to build against the BNE-enabled controller.
module tb_mc_alu_controller;
    localparam int T = 16;
    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, SLT = 3'b111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } o_t;

    logic clk = 1'b0;
    logic rst_n;
    mc_alu_controller_if bus ();

    mc_alu_controller #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    o_t dut_o;
    assign dut_o = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                    bus.pc_en, bus.iord, bus.mem_read, bus.mem_write,
                    bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                    bus.instr_done, bus.illegal, bus.bus_err};

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    o_t seen;
    o_t hist [0:63];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // The one compare point: sample at negedge, then advance to posedge+1.
    task automatic cyc(input o_t e, input string nm);
        @(negedge clk);
        seen = dut_o;
        n_tests++;
        if (seen !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, seen, e);
        end
        ncyc++;
        if (ncyc < 64) hist[ncyc] = seen;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'($urandom % 2);
        bus.zero      = 1'($urandom % 2);
    endtask

    function automatic o_t base(input logic [2:0] op);
        o_t e;
        e = '0;
        e.alu_op = op;
        return e;
    endfunction

    // stall<0: random ready; otherwise ready exactly at wait index == stall.
    task automatic mem_phase(input o_t b, input bit fetch, input bit wr,
                             input int stall, input string nm, output bit to);
        o_t e;
        bit fin;
        int k;
        fin = 0;
        to  = 0;
        k   = 0;
        while (!fin) begin
            bus.mem_ready = (stall < 0) ? 1'($urandom % 2) : (k == stall);
            e = b;
            if (bus.mem_ready) begin
                if (fetch) begin
                    e.ir_write = 1;
                    e.pc_en    = 1;
                end
                if (wr) e.instr_done = 1;
                fin = 1;
            end else if (k == T - 1) begin
                e.bus_err = 1;
                fin = 1;
                to  = 1;
            end
            cyc(e, nm);
            k++;
        end
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b001010, 6'b000010: return 1;
`ifdef MC_CTRL_BNE_EN
            6'b000101: return 1;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int sf, input int sm, input int z,
                             input bit abort_rd);
        o_t e;
        bit to;
        bus.opcode = op;
        bus.funct  = fn;
        e = base(ADD);
        e.mem_read = 1;
        e.src_b    = 2'b01;
        mem_phase(e, 1, 0, sf, "fetch", to);
        if (to) return;
        e = base(ADD);
        e.src_b   = 2'b11;
        e.illegal = !op_legal(op);
        cyc(e, "decode");
        if (e.illegal) return;
        e = base(ADD);
        case (op)
            6'b000000: begin
                e.src_a = 1;
                if (fn == 6'b100010) e.alu_op = SUB;
                else if (fn == 6'b101010) e.alu_op = SLT;
                else if (fn != 6'b100000) e.illegal = 1;
                cyc(e, "rtype_ex");
                if (e.illegal) return;
                e = base(ADD);
                e.reg_dst    = 1;
                e.reg_write  = 1;
                e.instr_done = 1;
                cyc(e, "rtype_wb");
            end
            6'b100011, 6'b101011: begin
                e.src_a = 1;
                e.src_b = 2'b10;
                cyc(e, "memadr");
                e = base(ADD);
                e.iord = 1;
                if (op == 6'b101011) begin
                    e.mem_write = 1;
                    mem_phase(e, 0, 1, sm, "memwr", to);
                end else if (abort_rd) begin
                    e.mem_read = 1;
                    bus.mem_ready = 0;
                    cyc(e, "memrd");
                end else begin
                    e.mem_read = 1;
                    mem_phase(e, 0, 0, sm, "memrd", to);
                    if (!to) begin
                        e = base(ADD);
                        e.mem_to_reg = 1;
                        e.reg_write  = 1;
                        e.instr_done = 1;
                        cyc(e, "memwb");
                    end
                end
            end
            6'b000100, 6'b000101: begin
                if (z >= 0) bus.zero = 1'(z);
                e.src_a      = 1;
                e.alu_op     = SUB;
                e.pc_src     = 2'b01;
                e.pc_en      = (op == 6'b000100) ? bus.zero : !bus.zero;
                e.instr_done = 1;
                cyc(e, "branch");
            end
            6'b001000, 6'b001010: begin
                e.src_a  = 1;
                e.src_b  = 2'b10;
                e.alu_op = (op == 6'b001010) ? SLT : ADD;
                cyc(e, "imm_ex");
                e = base(ADD);
                e.reg_write  = 1;
                e.instr_done = 1;
                cyc(e, "imm_wb");
            end
            default: begin
                e.pc_src     = 2'b10;
                e.pc_en      = 1;
                e.instr_done = 1;
                cyc(e, "jump");
            end
        endcase
    endtask

    logic [5:0] ops [0:9];
    logic [5:0] fns [0:4];

    initial begin
        int done_at, rd_cnt, irw;
        int sf, sm;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                6'b001010, 6'b000010, 6'b000101, 6'b111111, 6'b000011};
        fns = '{6'b100000, 6'b100010, 6'b101010, 6'b100100, 6'b000000};
        rst_n = 0;
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 0;
        bus.mem_ready = 0;
        #1;
        cyc('0, "reset");
        cyc('0, "reset");
        rst_n = 1;
        cyc('0, "start");

        // R-type SLT, no stalls
        ncyc = 0;
        run_instr(6'b000000, 6'b101010, 0, 0, -1, 0);
        done_at = 0;
        for (int i = 4; i >= 1; i--) if (hist[i].instr_done) done_at = i;
        chk("rt_done_cycle", done_at, 4);
        chk("rt_slt_op", int'(hist[3].alu_op), 7);
        chk("rt_wb_write", int'(hist[4].reg_write), 1);

        // BEQ taken / not taken
        ncyc = 0;
        run_instr(6'b000100, 6'b0, 0, 0, 1, 0);
        chk("beq_z1_pcen", int'(hist[3].pc_en), 1);
        chk("beq_z1_pcsrc", int'(hist[3].pc_src), 1);
        chk("beq_z1_op", int'(hist[3].alu_op), 6);
        ncyc = 0;
        run_instr(6'b000100, 6'b0, 0, 0, 0, 0);
        chk("beq_z0_pcen", int'(hist[3].pc_en), 0);
        chk("beq_z0_op", int'(hist[3].alu_op), 6);

        // lw with 3 stall cycles in MEMRD
        ncyc = 0;
        run_instr(6'b100011, 6'b0, 0, 3, -1, 0);
        rd_cnt = 0;
        for (int i = 1; i <= 10; i++)
            if (hist[i].iord && hist[i].mem_read) rd_cnt++;
        chk("lw_memrd_cycles", rd_cnt, 4);
        chk("lw_memwb_m2r", int'(hist[8].mem_to_reg), 1);

        // FETCH timeout, then a jump from the re-entered FETCH
        ncyc = 0;
        run_instr(6'b000010, 6'b0, 99, 0, -1, 0);
        run_instr(6'b000010, 6'b0, 0, 0, -1, 0);
        irw = 0;
        for (int i = 1; i <= 16; i++) irw += int'(hist[i].ir_write);
        chk("to_ir_never", irw, 0);
        chk("to_berr_c15", int'(hist[15].bus_err), 0);
        chk("to_berr_c16", int'(hist[16].bus_err), 1);
        chk("to_refetch", int'(hist[17].mem_read && hist[17].ir_write), 1);

        // ready on the last allowed wait cycle wins over timeout
        ncyc = 0;
        run_instr(6'b101011, 6'b0, T - 1, T - 1, -1, 0);
        chk("late_ready_no_err", int'(hist[16].bus_err), 0);
        chk("late_ready_ir", int'(hist[16].ir_write), 1);

        // opcode 000101
        ncyc = 0;
        run_instr(6'b000101, 6'b0, 0, 0, 0, 0);
`ifdef MC_CTRL_BNE_EN
        chk("bne_z0_pcen", int'(hist[3].pc_en), 1);
`else
        chk("bne_illegal", int'(hist[2].illegal), 1);
`endif

        // reset in the middle of MEMRD
        run_instr(6'b100011, 6'b0, 0, 0, -1, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_zero", int'(dut_o), 0);
        cyc('0, "in_reset");
        rst_n = 1;
        ncyc = 0;
        cyc('0, "start_after_rst");
        run_instr(6'b001000, 6'b0, 0, 0, -1, 0);
        chk("rst_start_zero", int'(hist[1]), 0);
        chk("rst_then_fetch", int'(hist[2].mem_read), 1);

        // random instruction mix
        for (int n = 0; n < 400; n++) begin
            sf = ($urandom % 8 == 0) ? int'($urandom_range(0, T + 2)) : -1;
            sm = ($urandom % 8 == 0) ? int'($urandom_range(0, T + 2)) : -1;
            run_instr(($urandom % 5 == 0) ? 6'($urandom) : ops[$urandom % 10],
                      ($urandom % 6 == 0) ? 6'($urandom) : fns[$urandom % 5],
                      sf, sm, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
